wide_block_serializer: RTL

- Transmit-side counterpart of the block-serial adder datapath.
- Accepts one (N+1)-bit signed operand (bit N is the sign) and emits it as N/Block chunks of Block bits over a valid/ready stream.
- Order is selectable per load: LSB-first or MSB-first.
- Feeds block-serial arithmetic and memory paths that consume one Block-bit slice per cycle.

---
 rtl/wide_block_serializer_if.sv | 42 ++++
 rtl/wide_block_serializer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/wide_block_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : wide_block_serializer_if
//  Description : Load / chunk-stream bundle for wide_block_serializer.
//                slave  - the serializer (takes loads, drives the chunk stream)
//                master - the environment (issues loads, consumes chunks)
//  Signals     : ld_vld/ld_rdy/ld_data/ld_msb_first  load handshake + operand
//                abort                               cancel in-flight transfer
//                blk_data/blk_idx/blk_sign/blk_last  current chunk
//                blk_vld/blk_rdy                     chunk handshake
//                busy/done                           status
//  Revision    : 1.0 - initial release
// ============================================================================
interface wide_block_serializer_if #(
    parameter int N     = 4096,
    parameter int BLOCK = 128
);
    logic             ld_vld;
    logic             ld_rdy;
    logic [N:0]       ld_data;
    logic             ld_msb_first;
    logic             abort;
    logic [BLOCK-1:0] blk_data;
    logic [7:0]       blk_idx;
    logic             blk_sign;
    logic             blk_last;
    logic             blk_vld;
    logic             blk_rdy;
    logic             busy;
    logic             done;

    modport slave (
        input  ld_vld, ld_data, ld_msb_first, abort, blk_rdy,
        output ld_rdy, blk_data, blk_idx, blk_sign, blk_last, blk_vld, busy, done
    );

    modport master (
        output ld_vld, ld_data, ld_msb_first, abort, blk_rdy,
        input  ld_rdy, blk_data, blk_idx, blk_sign, blk_last, blk_vld, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/wide_block_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : wide_block_serializer
//  Description : Takes one (N+1)-bit signed operand (bit N = sign) and emits
//                its magnitude as N/BLOCK chunks of BLOCK bits on a
//                valid/ready stream, LSB-first or MSB-first (chosen per load).
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous, active-high reset
//                bus  - wide_block_serializer_if.slave (load + chunk stream)
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_block_serializer #(
    parameter int N     = 4096,
    parameter int BLOCK = 128
) (
    input  wire logic              clk,
    input  wire logic              rst,
    wide_block_serializer_if.slave bus
);
    // Chunks per operand; derived, never set from outside.
    localparam int         c_MAX  = N / BLOCK;
    localparam logic [7:0] c_LAST = 8'(c_MAX - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [N-1:0] r_hold;
    logic [7:0]   r_count;
    logic         r_msb_first;
    logic         r_sign;
    logic         r_done;

    logic         w_load;
    logic         w_fire;
    logic         w_last;
    logic         w_abort;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_fire       = 1'b0;
        w_last       = 1'b0;
        w_abort      = 1'b0;
        bus.ld_rdy   = 1'b0;
        bus.blk_vld  = 1'b0;
        bus.busy     = 1'b0;
        bus.blk_last = 1'b0;
        bus.blk_data = '0;
        bus.blk_idx  = '0;
        bus.blk_sign = r_sign;
        bus.done     = r_done;

        case (r_state)
            c_ST_IDLE: begin
                bus.ld_rdy = 1'b1;
                // abort has no meaning here; a concurrent load still wins.
                if (bus.ld_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                bus.blk_vld  = 1'b1;
                bus.busy     = 1'b1;
                w_last       = (r_count == c_LAST);
                bus.blk_last = w_last;
                w_fire       = bus.blk_rdy;
                w_abort      = bus.abort;
                // The outgoing chunk always sits at one end of the holding
                // register; the shift direction follows the order flag.
                if (r_msb_first) begin
                    bus.blk_data = r_hold[N-1 -: BLOCK];
                    bus.blk_idx  = c_LAST - r_count;
                end else begin
                    bus.blk_data = r_hold[BLOCK-1:0];
                    bus.blk_idx  = r_count;
                end
                if (bus.abort || (bus.blk_rdy && w_last)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: holding register, chunk counter, captured flags, done pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_count     <= '0;
            r_msb_first <= 1'b0;
            r_sign      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_hold      <= bus.ld_data[N-1:0];
                r_sign      <= bus.ld_data[N];
                r_msb_first <= bus.ld_msb_first;
                r_count     <= '0;
            end else if (w_abort) begin
                // Abort beats a coincident final handshake: no done pulse.
                r_hold  <= '0;
                r_count <= '0;
            end else if (w_fire) begin
                if (w_last) begin
                    r_hold  <= '0;
                    r_count <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_hold  <= r_msb_first ? (r_hold << BLOCK) : (r_hold >> BLOCK);
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire
